// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and defaults for the systolic array edge skew feeder.
package systolic_skew_feeder_pkg;

    localparam int unsigned N_DEF       = 4;
    localparam int unsigned DW_DEF      = 8;
    localparam int unsigned MAX_LEN_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_e;

    // Bit offset of lane `lane` inside a packed vector of `dw`-bit elements.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Operand stream in, skewed lane bus out, plus status, for one array edge.
interface systolic_skew_feeder_if
    import systolic_skew_feeder_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic            s_valid;
    logic            s_ready;
    logic [N*DW-1:0] s_data;
    logic            s_last;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_valid;
    logic            busy;
    logic            done;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, out_data, out_valid, busy, done
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// Per-lane {valid,data} shift register; DEPTH extra stages behind one output register.
module skew_delay_line #(
    parameter int unsigned DEPTH = 0,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          i_clr_n,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);
    localparam int unsigned STAGES = DEPTH + 1;

    logic          r_valid [STAGES];
    logic [DW-1:0] r_data  [STAGES];

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int k = 1; k < int'(STAGES); k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    assign o_valid = r_valid[STAGES-1];
    assign o_data  = r_data[STAGES-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Accepts operand vectors and drives them diagonally skewed onto the array edge.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    systolic_skew_feeder_if.slave bus
);
    localparam int unsigned CW     = $clog2(MAX_LEN + 1);
    localparam int unsigned FW     = $clog2(N + 1);
    localparam logic        SINGLE = 1'(MAX_LEN == 1);

    feeder_state_e   r_state;
    logic [CW-1:0]   r_count;
    logic [FW-1:0]   r_flush;
    logic            r_busy;
    logic            r_done;

    logic            w_ready;
    logic            w_accept;
    logic            w_last;
    logic [N-1:0]    w_out_valid;
    logic [N*DW-1:0] w_out_data;

    // Ready depends on state only so upstream can never form a loop through s_valid.
    assign w_ready  = reset & ((r_state == IDLE) | (r_state == STREAM));
    assign w_accept = bus.s_valid & w_ready;
    // The MAX_LEN-th vector closes the matrix even without s_last.
    assign w_last   = bus.s_last |
                      ((r_state == IDLE) ? SINGLE : (r_count == CW'(MAX_LEN - 1)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_flush <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_count <= CW'(1);
                        r_busy  <= 1'b1;
                        if (w_last) begin
                            r_state <= FLUSH;
                            r_flush <= FW'(N);
                        end else begin
                            r_state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        r_count <= r_count + CW'(1);
                        if (w_last) begin
                            r_state <= FLUSH;
                            r_flush <= FW'(N);
                        end
                    end
                end
                FLUSH: begin
                    if (r_flush == FW'(1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_flush <= r_flush - FW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Lane j sits j cycles behind lane 0; idle cycles inject zero bubbles.
    for (genvar j = 0; j < int'(N); j++) begin : g_lane
        localparam int unsigned LSB = lane_lsb(j, DW);
        logic [DW-1:0] w_in;

        assign w_in = w_accept ? bus.s_data[LSB +: DW] : '0;

        skew_delay_line #(
            .DEPTH (j),
            .DW    (DW)
        ) u_line (
            .clk     (clk),
            .i_clr_n (reset),
            .i_valid (w_accept),
            .i_data  (w_in),
            .o_valid (w_out_valid[j]),
            .o_data  (w_out_data[LSB +: DW])
        );
    end

    assign bus.s_ready   = w_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
